lsu_mem_master: RTL and testbench



---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_mem_master_if.sv | 41 ++++
 rtl/lsu_align.sv | 49 ++++
 rtl/lsu_mem_master.sv | 155 +++++++++++++++
 tb/tb_lsu_mem_master.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store initiator.
//   - RISC-V load/store funct3 encodings
//   - FSM state encoding (also exported on the debug port)
//   - Default data RAM and GPIO window base addresses
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // funct3[1:0] is the access size: 00 byte, 01 halfword, 10 word.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [31:0] LSU_DMEM_BASE = 32'h0200_0000;
  localparam logic [31:0] LSU_GPIO_BASE = 32'h0200_00F0;
  localparam int          LSU_GPIO_BYTES = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WR     = 3'd3,
    ST_RESP   = 3'd4
  } lsu_state_e;

endpackage

// File: rtl/lsu_mem_master_if.sv
// Request/response and responder bus of the load/store initiator.
//   master modport : the initiator (lsu_mem_master)
//   slave modport  : the core-side requester plus data memory/GPIO responder
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1; the requester holds req_* stable until then.
// req_ready is 1 only when no request is outstanding. The response is a
// single-cycle rsp_valid pulse with no backpressure; rsp_rdata/rsp_err are
// meaningful while rsp_valid is 1 and hold until the next response.
// mem_rd_data is a combinational function of mem_addr; a write happens on
// each rising edge where mem_wr_en is 1.
interface lsu_mem_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  modport master (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_wr_en, mem_addr, mem_wr_data
  );

  modport slave (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_wr_en, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/lsu_align.sv
// Lane steering for 32-bit words.
//   funct3   : load/store funct3 of the current access
//   addr_lo  : byte offset within the word
//   rd_word  : word read from the responder (load path)
//   old_word : word sampled before a sub-word store
//   wdata    : right-aligned store data
//   ld_data  : extracted and sign/zero-extended load result
//   st_word  : word to write (old word with one lane replaced, or wdata)
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rd_word,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rd_word[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];

    ld_data = '0;
    case (funct3)
      F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   ld_data = {24'h0, byte_sel};
      F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   ld_data = {16'h0, half_sel};
      F3_W:    ld_data = rd_word;
      default: ld_data = '0;
    endcase

    st_word = old_word;
    case (funct3[1:0])
      SZ_B: st_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      SZ_H: begin
        if (addr_lo[1]) st_word[31:16] = wdata[15:0];
        else            st_word[15:0]  = wdata[15:0];
      end
      default: st_word = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator between the execute stage and data memory/GPIO.
// Accepts one request at a time, decodes size/alignment/region at accept,
// performs loads in one memory cycle and sub-word stores as read-modify-write,
// then returns a one-cycle response.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : request/response/responder signals (master modport)
//   dbg_state  : current FSM state
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    MEM_SIZE   = 512,
  parameter logic [ADDR_WIDTH-1:0] DMEM_BASE  = LSU_DMEM_BASE,
  parameter logic [ADDR_WIDTH-1:0] GPIO_BASE  = LSU_GPIO_BASE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lsu_mem_master_if.master      bus,
  output lsu_state_e            dbg_state
);

  localparam logic [ADDR_WIDTH-1:0] DMEM_END = DMEM_BASE + ADDR_WIDTH'(MEM_SIZE * 4);
  localparam logic [ADDR_WIDTH-1:0] GPIO_END = GPIO_BASE + ADDR_WIDTH'(LSU_GPIO_BYTES);

  lsu_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] old_q, old_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  accept;
  logic [1:0]            req_size;
  logic                  f3_ok, misalign, in_gpio, in_dmem, dec_err;
  logic [DATA_WIDTH-1:0] ld_data, st_word;

  // Decode of the incoming request; only consumed on the accept edge.
  always_comb begin
    req_size = bus.req_funct3[1:0];
    f3_ok    = bus.req_we ? (bus.req_funct3 inside {F3_B, F3_H, F3_W})
                          : (bus.req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misalign = ((req_size == SZ_H) && bus.req_addr[0]) ||
               ((req_size == SZ_W) && (bus.req_addr[1:0] != 2'b00));
    in_gpio  = (bus.req_addr >= GPIO_BASE) && (bus.req_addr < GPIO_END);
    in_dmem  = (bus.req_addr >= DMEM_BASE) && (bus.req_addr < DMEM_END);
    // GPIO wins over the overlapping data RAM range and is word-only.
    dec_err  = !f3_ok || misalign || (in_gpio ? (req_size != SZ_W) : !in_dmem);
    accept   = bus.req_valid && (state_q == ST_IDLE);
  end

  lsu_align u_align (
    .funct3   (f3_q),
    .addr_lo  (addr_q[1:0]),
    .rd_word  (bus.mem_rd_data),
    .old_word (old_q),
    .wdata    (wdata_q),
    .ld_data  (ld_data),
    .st_word  (st_word)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      wdata_q <= wdata_d;
      old_q   <= old_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (dec_err)                 state_d = ST_RESP;
          else if (!bus.req_we)        state_d = ST_RD;
          else if (req_size == SZ_W)   state_d = ST_WR;
          else                         state_d = ST_RMW_RD;
        end
      end
      ST_RD:     state_d = ST_RESP;
      ST_RMW_RD: state_d = ST_WR;
      ST_WR:     state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath updates. Response data/error are written only on the edge that
  // enters RESP, so they hold between responses.
  always_comb begin
    addr_d  = addr_q;
    we_d    = we_q;
    f3_d    = f3_q;
    wdata_d = wdata_q;
    old_d   = old_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = bus.req_addr;
          we_d    = bus.req_we;
          f3_d    = bus.req_funct3;
          wdata_d = bus.req_wdata;
          if (dec_err) begin
            rdata_d = '0;
            err_d   = 1'b1;
          end
        end
      end
      ST_RD: begin
        rdata_d = ld_data;
        err_d   = 1'b0;
      end
      ST_RMW_RD: old_d = bus.mem_rd_data;
      ST_WR: begin
        rdata_d = '0;
        err_d   = 1'b0;
      end
      default: ;
    endcase
  end

  // Outputs, decoded from the current state.
  always_comb begin
    bus.req_ready   = (state_q == ST_IDLE);
    bus.rsp_valid   = (state_q == ST_RESP);
    bus.rsp_rdata   = rdata_q;
    bus.rsp_err     = err_q;
    bus.mem_wr_en   = (state_q == ST_WR);
    bus.mem_addr    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    bus.mem_wr_data = (state_q == ST_WR) ? st_word : '0;
    dbg_state       = state_q;
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
module tb_lsu_mem_master;
  import lsu_pkg::*;

  localparam int MEM_WORDS = 512;

  logic       clk;
  logic       rst_n;
  lsu_state_e dbg_state;
  int         checks = 0;
  int         errors = 0;
  int         wr_total = 0;
  logic [31:0] last_rdata;

  // Responder storage and the reference model's own copy.
  logic [31:0] resp_dmem [MEM_WORDS];
  logic [31:0] resp_gpio [4];
  logic [31:0] ref_dmem  [MEM_WORDS];
  logic [31:0] ref_gpio  [4];

  lsu_mem_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  lsu_mem_master #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SIZE(MEM_WORDS),
    .DMEM_BASE(LSU_DMEM_BASE), .GPIO_BASE(LSU_GPIO_BASE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- address helpers ----------------
  function automatic bit is_gpio(input logic [31:0] a);
    return (a >= LSU_GPIO_BASE) && (a < LSU_GPIO_BASE + 32'd16);
  endfunction

  function automatic bit is_dmem(input logic [31:0] a);
    return (a >= LSU_DMEM_BASE) && (a < LSU_DMEM_BASE + 32'(MEM_WORDS * 4));
  endfunction

  function automatic int dmem_idx(input logic [31:0] a);
    return int'((a - LSU_DMEM_BASE) / 4);
  endfunction

  // ---------------- responder ----------------
  always_comb begin
    bus.mem_rd_data = 32'hDEAD_BEEF;
    if (is_gpio(bus.mem_addr))      bus.mem_rd_data = resp_gpio[bus.mem_addr[3:2]];
    else if (is_dmem(bus.mem_addr)) bus.mem_rd_data = resp_dmem[dmem_idx(bus.mem_addr)];
  end

  always @(posedge clk) begin
    if (bus.mem_wr_en) begin
      wr_total <= wr_total + 1;
      if (is_gpio(bus.mem_addr))      resp_gpio[bus.mem_addr[3:2]] <= bus.mem_wr_data;
      else if (is_dmem(bus.mem_addr)) resp_dmem[dmem_idx(bus.mem_addr)] <= bus.mem_wr_data;
    end
  end

  function automatic logic [31:0] resp_read(input logic [31:0] a);
    if (is_gpio(a)) return resp_gpio[a[3:2]];
    if (is_dmem(a)) return resp_dmem[dmem_idx(a)];
    return 32'h0;
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (is_gpio(a)) return ref_gpio[a[3:2]];
    if (is_dmem(a)) return ref_dmem[dmem_idx(a)];
    return 32'h0;
  endfunction

  function automatic void ref_write(input logic [31:0] a, input logic [31:0] w);
    if (is_gpio(a))      ref_gpio[a[3:2]] = w;
    else if (is_dmem(a)) ref_dmem[dmem_idx(a)] = w;
  endfunction

  function automatic bit model_err(input bit we, input int f3, input logic [31:0] a);
    int nbytes;
    bit legal;
    legal  = we ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
    if (!legal) return 1'b1;
    nbytes = 1 << (f3 % 4);
    if ((a % nbytes) != 0) return 1'b1;
    if (is_gpio(a)) return nbytes != 4;
    return !is_dmem(a);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input int f3, input logic [31:0] a);
    logic [31:0] b, h;
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (8 * (a % 4))) & 32'hFFFF;
    case (f3)
      0: return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      4: return b;
      1: return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      5: return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input int f3,
                                              input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] mask;
    int          sh;
    if (f3 == 2) return wd;
    mask = (f3 == 0) ? 32'h0000_00FF : 32'h0000_FFFF;
    sh   = 8 * int'(a % 4);
    return (old & ~(mask << sh)) | ((wd & mask) << sh);
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // ---------------- driver: one full request/response ----------------
  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input string tag);
    bit          exp_err;
    int          exp_lat, exp_wr, lat, wr_seen;
    bit          addr_bad;
    logic [31:0] exp_rdata, exp_word, old, wr_addr, wr_data, exp_maddr;

    exp_err   = model_err(we, int'(f3), addr);
    old       = ref_read(addr);
    exp_maddr = {addr[31:2], 2'b00};
    exp_word  = 32'h0;
    exp_rdata = 32'h0;
    exp_wr    = 0;
    if (exp_err)  exp_lat = 1;
    else if (!we) begin
      exp_lat   = 2;
      exp_rdata = model_load(old, int'(f3), addr);
    end else begin
      exp_lat  = (f3 == F3_W) ? 2 : 3;
      exp_word = model_store(old, int'(f3), addr, wdata);
      exp_wr   = 1;
    end

    for (int i = 0; i < 20 && bus.req_ready !== 1'b1; i++) @(negedge clk);
    check({tag, ".ready"}, 32'(bus.req_ready), 32'd1);

    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;

    wr_seen  = 0;
    addr_bad = 1'b0;
    wr_addr  = 32'h0;
    wr_data  = 32'h0;
    for (lat = 1; lat <= 8; lat++) begin
      @(negedge clk);
      if (lat == 1) begin
        bus.req_valid = 1'b0;
        bus.req_wdata = $urandom;
        bus.req_addr  = $urandom;
      end
      if (!exp_err && bus.mem_addr !== exp_maddr) addr_bad = 1'b1;
      if (bus.mem_wr_en) begin
        wr_seen++;
        wr_addr = bus.mem_addr;
        wr_data = bus.mem_wr_data;
      end
      if (bus.rsp_valid) break;
    end

    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".err"},     32'(bus.rsp_err), 32'(exp_err));
    check({tag, ".rdata"},   bus.rsp_rdata, exp_rdata);
    check({tag, ".wr_pulses"}, 32'(wr_seen), 32'(exp_wr));
    if (!exp_err) check({tag, ".mem_addr_stable"}, 32'(addr_bad), 32'd0);
    if (exp_wr == 1) begin
      check({tag, ".wr_addr"}, wr_addr, exp_maddr);
      check({tag, ".wr_data"}, wr_data, exp_word);
      ref_write(addr, exp_word);
      check({tag, ".mem_word"}, resp_read(addr), ref_read(addr));
    end
    last_rdata = bus.rsp_rdata;

    @(negedge clk);
    check({tag, ".rsp_pulse_end"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, ".rdata_hold"},    bus.rsp_rdata, exp_rdata);
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] w);
    resp_dmem[dmem_idx(addr)] = w;
    ref_dmem[dmem_idx(addr)]  = w;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] a, wd;
    logic [2:0]  f3;
    bit          we;
    int          sel, wr_snap;
    logic [2:0]  f3_pool [10];

    for (int i = 0; i < MEM_WORDS; i++) begin
      resp_dmem[i] = $urandom;
      ref_dmem[i]  = resp_dmem[i];
    end
    for (int i = 0; i < 4; i++) begin
      resp_gpio[i] = 32'h0;
      ref_gpio[i]  = 32'h0;
    end
    preload(32'h0200_0010, 32'h8899_AABC);
    preload(32'h0200_0004, 32'h80FF_7F01);
    preload(32'h0200_0020, 32'h1122_3344);
    preload(32'h0200_0030, 32'h5566_7788);

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    rst_n          = 1'b0;
    repeat (3) @(negedge clk);

    check("rst.req_ready",   32'(bus.req_ready), 32'd1);
    check("rst.rsp_valid",   32'(bus.rsp_valid), 32'd0);
    check("rst.rsp_err",     32'(bus.rsp_err),   32'd0);
    check("rst.rsp_rdata",   bus.rsp_rdata,      32'h0);
    check("rst.mem_wr_en",   32'(bus.mem_wr_en), 32'd0);
    check("rst.mem_addr",    bus.mem_addr,       32'h0);
    check("rst.mem_wr_data", bus.mem_wr_data,    32'h0);
    check("rst.state",       32'(dbg_state),     32'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Loads
    do_req(1'b0, F3_W,  32'h0200_0010, 32'h0, "lw");
    check("lw.const", last_rdata, 32'h8899_AABC);
    do_req(1'b0, F3_B,  32'h0200_0007, 32'h0, "lb");
    check("lb.const", last_rdata, 32'hFFFF_FF80);
    do_req(1'b0, F3_BU, 32'h0200_0007, 32'h0, "lbu");
    check("lbu.const", last_rdata, 32'h0000_0080);
    do_req(1'b0, F3_H,  32'h0200_0004, 32'h0, "lh");
    check("lh.const", last_rdata, 32'h0000_7F01);
    do_req(1'b0, F3_HU, 32'h0200_0006, 32'h0, "lhu");
    check("lhu.const", last_rdata, 32'h0000_80FF);

    // Sub-word stores (read-modify-write)
    do_req(1'b1, F3_B, 32'h0200_0021, 32'h0000_00AB, "sb");
    check("sb.const", resp_dmem[8], 32'h1122_AB44);
    do_req(1'b1, F3_H, 32'h0200_0022, 32'h0000_BEEF, "sh");
    check("sh.const", resp_dmem[8], 32'hBEEF_AB44);

    // Decode errors: no memory cycle
    do_req(1'b0, F3_W,   32'h0200_0002, 32'h0,         "err_misalign");
    do_req(1'b1, F3_W,   32'h0300_0000, 32'h1234_5678, "err_unmapped");
    do_req(1'b1, F3_B,   32'h0200_00F0, 32'h0000_0055, "err_gpio_sub");
    do_req(1'b0, 3'b011, 32'h0200_0010, 32'h0,         "err_funct3");

    // GPIO window overlaps the data RAM range and takes priority
    do_req(1'b1, F3_W, 32'h0200_00F4, 32'h0000_0001, "gpio_sw");
    check("gpio_sw.gpio_reg", resp_gpio[1], 32'h0000_0001);
    do_req(1'b0, F3_W, 32'h0200_00F4, 32'h0, "gpio_lw");
    check("gpio_lw.const", last_rdata, 32'h0000_0001);

    // Randomized traffic against the reference model
    f3_pool = '{F3_B, F3_H, F3_W, F3_BU, F3_HU, F3_B, F3_H, F3_W, 3'b011, 3'b110};
    for (int n = 0; n < 60; n++) begin
      we  = 1'($urandom_range(0, 1));
      f3  = f3_pool[$urandom_range(0, 9)];
      sel = $urandom_range(0, 9);
      if (sel <= 6)      a = LSU_DMEM_BASE + 32'($urandom_range(0, MEM_WORDS * 4 - 1));
      else if (sel <= 8) a = LSU_GPIO_BASE + 32'($urandom_range(0, 15));
      else               a = 32'h0300_0000 + 32'($urandom_range(0, 255));
      if ((sel % 2) == 0 && f3[1:0] == SZ_W) a[1:0] = 2'b00;
      if ((sel % 2) == 0 && f3[1:0] == SZ_H) a[0]   = 1'b0;
      wd = $urandom;
      do_req(we, f3, a, wd, "rand");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset during the read phase of a read-modify-write
    wr_snap        = wr_total;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_B;
    bus.req_addr   = 32'h0200_0030;
    bus.req_wdata  = 32'h0000_00CC;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rmw_rst.in_rmw_rd", 32'(dbg_state), 32'(ST_RMW_RD));
    rst_n = 1'b0;
    #1;
    check("rmw_rst.req_ready",   32'(bus.req_ready), 32'd1);
    check("rmw_rst.rsp_valid",   32'(bus.rsp_valid), 32'd0);
    check("rmw_rst.rsp_err",     32'(bus.rsp_err),   32'd0);
    check("rmw_rst.rsp_rdata",   bus.rsp_rdata,      32'h0);
    check("rmw_rst.mem_wr_en",   32'(bus.mem_wr_en), 32'd0);
    check("rmw_rst.mem_addr",    bus.mem_addr,       32'h0);
    check("rmw_rst.mem_wr_data", bus.mem_wr_data,    32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rmw_rst.ready_after", 32'(bus.req_ready), 32'd1);
    check("rmw_rst.state_after", 32'(dbg_state),     32'(ST_IDLE));
    check("rmw_rst.no_write",    32'(wr_total),      32'(wr_snap));
    check("rmw_rst.mem_word",    resp_dmem[12],      32'h5566_7788);

    // Normal operation resumes after the interrupted store
    do_req(1'b1, F3_B, 32'h0200_0031, 32'h0000_00CC, "post_rst_sb");
    check("post_rst_sb.const", resp_dmem[12], 32'h5566_CC88);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
